// File: rtl/feeder_pkg.sv
// Shared definitions for the systolic array feeder.
// Holds the feeder state encoding and the timing constants that tie the
// feeder run length to the PE pipeline depth.
package feeder_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Zero-lane cycles after the last slice so the final product reaches
    // the PE output register before done is flagged.
    localparam int unsigned DRAIN_CYCLES = 3;
    localparam int unsigned PE_LATENCY   = 4;
    localparam int unsigned FRAC_BITS    = 6;

endpackage

// File: rtl/operand_buffer.sv
// Operand store of N lanes by K_MAX words, one write port, registered read
// of all N lanes at a single inner index.
// Ports: clk, rst (sync active-low, clears read register only),
//        wr_en/wr_lane/wr_k/wr_data (write port),
//        rd_en/rd_k (read request), rd_data (N lanes, zero when not reading).
module operand_buffer #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned N          = 4,
    parameter int unsigned K_MAX      = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_en,
    input  logic [$clog2(N)-1:0]             wr_lane,
    input  logic [$clog2(K_MAX)-1:0]         wr_k,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic                             rd_en,
    input  logic [$clog2(K_MAX)-1:0]         rd_k,
    output logic [N*DATA_WIDTH-1:0]          rd_data
);

    logic [DATA_WIDTH-1:0]   mem_q [N][K_MAX];
    logic [N*DATA_WIDTH-1:0] rd_data_d;
    logic [N*DATA_WIDTH-1:0] rd_data_q;

    // Storage is deliberately not reset so operands survive a mid-run reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_lane][wr_k] <= wr_data;
        end
    end

    // Gather one word per lane; zero lanes whenever no slice is requested.
    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < int'(N); i++) begin
            rd_data_d[i*DATA_WIDTH +: DATA_WIDTH] = rd_en ? mem_q[i][rd_k] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/systolic_feeder.sv
// Source side of the matrix-multiply datapath: buffers A and B, clears the
// PE array on start, streams one aligned K-slice per cycle, drains, flags done.
// Ports: clk, rst (sync active-low), wr_* (buffer load, IDLE only),
//        k_len/start (run request), data_out/weight_out (lanes),
//        valid_out, pe_clear, busy, done (registered status).
module systolic_feeder
    import feeder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned N          = 4,
    parameter int unsigned K_MAX      = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic                           wr_sel,
    input  logic [$clog2(N)-1:0]           wr_lane,
    input  logic [$clog2(K_MAX)-1:0]       wr_k,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic [$clog2(K_MAX):0]         k_len,
    input  logic                           start,
    output logic [N*DATA_WIDTH-1:0]        data_out,
    output logic [N*DATA_WIDTH-1:0]        weight_out,
    output logic                           valid_out,
    output logic                           pe_clear,
    output logic                           busy,
    output logic                           done
);

    localparam int unsigned KW  = $clog2(K_MAX);
    localparam int unsigned KCW = KW + 1;
    localparam int unsigned DCW = $clog2(DRAIN_CYCLES);

    state_t           state_q, state_d;
    logic [KCW-1:0]   k_q, k_d;
    logic [KCW-1:0]   klen_q, klen_d;
    logic [DCW-1:0]   drain_q, drain_d;
    logic             valid_q, valid_d;
    logic             pe_clear_q, pe_clear_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             wr_ok;
    logic             rd_en;
    logic [KW-1:0]    rd_k;

    // Writes land only while idle; a write alongside start still completes.
    assign wr_ok = wr_en && (state_q == IDLE);
    // Slice k is fetched on the edge that enters/stays in STREAM.
    assign rd_en = (state_d == STREAM);
    assign rd_k  = KW'(k_q);

    operand_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .N          (N),
        .K_MAX      (K_MAX)
    ) u_buf_a (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_ok && !wr_sel),
        .wr_lane (wr_lane),
        .wr_k    (wr_k),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_k    (rd_k),
        .rd_data (data_out)
    );

    operand_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .N          (N),
        .K_MAX      (K_MAX)
    ) u_buf_b (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_ok && wr_sel),
        .wr_lane (wr_lane),
        .wr_k    (wr_k),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_k    (rd_k),
        .rd_data (weight_out)
    );

    // Next state, counters and the registered status outputs of the state entered.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        klen_d     = klen_q;
        drain_d    = drain_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    klen_d  = (k_len > KCW'(K_MAX)) ? KCW'(K_MAX) : k_len;
                    k_d     = '0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                drain_d = '0;
                state_d = (klen_q == '0) ? DRAIN : STREAM;
            end
            STREAM: begin
                drain_d = '0;
                // k_q counts slices already fetched; all fetched means done streaming.
                if (k_q == klen_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_q == DCW'(DRAIN_CYCLES - 1)) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + DCW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == STREAM) begin
            k_d = k_q + KCW'(1);
        end

        valid_d    = (state_d == STREAM);
        pe_clear_d = (state_d == CLEAR);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            k_q        <= '0;
            klen_q     <= '0;
            drain_q    <= '0;
            valid_q    <= 1'b0;
            pe_clear_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            klen_q     <= klen_d;
            drain_q    <= drain_d;
            valid_q    <= valid_d;
            pe_clear_q <= pe_clear_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign valid_out = valid_q;
    assign pe_clear  = pe_clear_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: a timeline model of each run
// (cycle offset from start) against shadow copies of the A and B buffers.
module tb_systolic_feeder;

    localparam int unsigned DW    = 12;
    localparam int unsigned N     = 4;
    localparam int unsigned K_MAX = 16;
    localparam int unsigned LW    = $clog2(N);
    localparam int unsigned KW    = $clog2(K_MAX);

    logic                clk = 1'b0;
    logic                rst;
    logic                wr_en;
    logic                wr_sel;
    logic [LW-1:0]       wr_lane;
    logic [KW-1:0]       wr_k;
    logic [DW-1:0]       wr_data;
    logic [KW:0]         k_len;
    logic                start;
    logic [N*DW-1:0]     data_out;
    logic [N*DW-1:0]     weight_out;
    logic                valid_out;
    logic                pe_clear;
    logic                busy;
    logic                done;

    logic [DW-1:0] a_m [N][K_MAX];
    logic [DW-1:0] b_m [N][K_MAX];

    int n_pass = 0;
    int n_total = 0;
    logic [N*DW-1:0] first_seq [K_MAX];

    systolic_feeder #(.DATA_WIDTH(DW), .N(N), .K_MAX(K_MAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_lane    (wr_lane),
        .wr_k       (wr_k),
        .wr_data    (wr_data),
        .k_len      (k_len),
        .start      (start),
        .data_out   (data_out),
        .weight_out (weight_out),
        .valid_out  (valid_out),
        .pe_clear   (pe_clear),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [N*DW-1:0] slice_a(input int k);
        logic [N*DW-1:0] v;
        v = '0;
        for (int i = 0; i < int'(N); i++) v[i*DW +: DW] = a_m[i][k];
        return v;
    endfunction

    function automatic logic [N*DW-1:0] slice_b(input int k);
        logic [N*DW-1:0] v;
        v = '0;
        for (int j = 0; j < int'(N); j++) v[j*DW +: DW] = b_m[j][k];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_buf(input bit sel, input int lane, input int k, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_lane = LW'(lane);
        wr_k    = KW'(k);
        wr_data = d;
        if (sel) b_m[lane][k] = d;
        else     a_m[lane][k] = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_data"},   64'(data_out), 64'(0));
        chk({tag, "_weight"}, 64'(weight_out), 64'(0));
        chk({tag, "_status"}, 64'({valid_out, pe_clear, busy, done}), 64'(0));
    endtask

    // One run: cycle c (1-based) is the c-th cycle after the edge that took start.
    // coll: write into A together with start. inj_c: pulse start+wr_en after
    // checking cycle inj_c. rst_c: assert reset after checking cycle rst_c.
    task automatic run(input int klen_in, input bit coll, input int inj_c, input int rst_c,
                       input bit record, input bit compare_rec);
        int eff;
        int lane;
        int kk;
        logic [DW-1:0] d;
        eff = (klen_in > int'(K_MAX)) ? int'(K_MAX) : klen_in;
        if (coll) begin
            lane = int'($urandom_range(N-1));
            kk   = (eff > 0) ? int'($urandom_range(eff-1)) : 0;
            d    = DW'($urandom);
            wr_en = 1'b1; wr_sel = 1'b0; wr_lane = LW'(lane); wr_k = KW'(kk); wr_data = d;
            a_m[lane][kk] = d;
        end
        k_len = (KW+1)'(klen_in);
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        for (int c = 1; c <= eff + 5; c++) begin
            bit v;
            v = (c >= 2) && (c <= eff + 1);
            chk($sformatf("busy_c%0d", c),  64'(busy), 64'(1));
            chk($sformatf("clr_c%0d", c),   64'(pe_clear), 64'(c == 1));
            chk($sformatf("valid_c%0d", c), 64'(valid_out), 64'(v));
            chk($sformatf("done_c%0d", c),  64'(done), 64'(c == eff + 5));
            chk($sformatf("data_c%0d", c),   64'(data_out),   v ? 64'(slice_a(c-2)) : 64'(0));
            chk($sformatf("weight_c%0d", c), 64'(weight_out), v ? 64'(slice_b(c-2)) : 64'(0));
            if (v && record) first_seq[c-2] = data_out ^ weight_out;
            if (v && compare_rec)
                chk($sformatf("repeat_c%0d", c), 64'(data_out ^ weight_out), 64'(first_seq[c-2]));
            if (c == inj_c) begin
                start = 1'b1; wr_en = 1'b1; wr_sel = 1'($urandom);
                wr_lane = LW'($urandom); wr_k = KW'($urandom_range(K_MAX-1));
                wr_data = DW'($urandom);
            end
            if (c == rst_c) begin
                rst = 1'b0;
                tick();
                rst = 1'b1;
                chk_idle_zero("midrun_rst");
                return;
            end
            tick();
            start = 1'b0;
            wr_en = 1'b0;
        end
        chk("post_run_busy", 64'(busy), 64'(0));
        chk("post_run_done", 64'(done), 64'(0));
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_lane = '0; wr_k = '0;
        wr_data = '0; k_len = '0; start = 1'b0;
        tick();
        tick();
        chk_idle_zero("reset");
        rst = 1'b1;
        tick();

        // Identity A, B[k][j] = k+j in Q5.6.
        for (int i = 0; i < int'(N); i++)
            for (int k = 0; k < int'(K_MAX); k++) begin
                write_buf(1'b0, i, k, (i == k) ? DW'(12'h040) : DW'(0));
                write_buf(1'b1, i, k, DW'((k + i) << 6));
            end
        run(4, 1'b0, 0, 0, 1'b0, 1'b0);

        // Random contents for the remaining scenarios.
        for (int i = 0; i < int'(N); i++)
            for (int k = 0; k < int'(K_MAX); k++) begin
                write_buf(1'b0, i, k, DW'($urandom));
                write_buf(1'b1, i, k, DW'($urandom));
            end

        run(8, 1'b0, 0, 4, 1'b0, 1'b0);
        run(8, 1'b0, 0, 0, 1'b0, 1'b0);
        run(0, 1'b0, 0, 0, 1'b0, 1'b0);
        run(16, 1'b0, 0, 0, 1'b0, 1'b0);
        run(20, 1'b0, 0, 0, 1'b0, 1'b0);
        run(6, 1'b0, 4, 0, 1'b0, 1'b0);
        run(6, 1'b0, 0, 0, 1'b0, 1'b0);
        run(5, 1'b1, 0, 0, 1'b0, 1'b0);
        run(int'($urandom_range(1, K_MAX)), 1'b1, 0, 0, 1'b0, 1'b0);
        run(7, 1'b0, 0, 0, 1'b1, 1'b0);
        run(7, 1'b0, 0, 0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
